// File: rtl/snd_pkg.sv
// rtl/snd_pkg.sv - shared sample type, limits, saturation helper and FSM state encoding
package snd_pkg;

    typedef logic signed [15:0] snd_sample_t;

    localparam snd_sample_t SND_MAX = 16'sh7FFF;
    localparam snd_sample_t SND_MIN = 16'sh8000;

    typedef enum logic [1:0] {IDLE, MAC, SAT} mix_state_t;

    function automatic snd_sample_t snd_sat(input logic signed [63:0] x);
        if (x > 64'(SND_MAX)) begin
            return SND_MAX;
        end else if (x < 64'(SND_MIN)) begin
            return SND_MIN;
        end else begin
            return snd_sample_t'(x[15:0]);
        end
    endfunction

endpackage

// File: rtl/snd_mixer_if.sv
// rtl/snd_mixer_if.sv - mixer source/volume/result bundle; clip_cnt present under SND_MIX_CLIP_CNT_EN
interface snd_mixer_if #(
    parameter int CHANNELS = 4,
    parameter int VOL_W    = 8
);
    import snd_pkg::*;

    localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                     snd_next_sample;
    logic [CHANNELS*16-1:0]   ch_l;
    logic [CHANNELS*16-1:0]   ch_r;
    logic                     vol_we;
    logic [AW-1:0]            vol_addr;
    logic [VOL_W-1:0]         vol_dat;
    logic                     mute;
    logic                     ovr_clr;
    snd_sample_t              snd_l;
    snd_sample_t              snd_r;
    logic                     mix_busy;
    logic                     mix_done;
    logic                     overrun;
`ifdef SND_MIX_CLIP_CNT_EN
    logic [15:0]              clip_cnt;
`endif

    modport master (
`ifdef SND_MIX_CLIP_CNT_EN
        input  clip_cnt,
`endif
        output snd_next_sample, ch_l, ch_r, vol_we, vol_addr, vol_dat, mute, ovr_clr,
        input  snd_l, snd_r, mix_busy, mix_done, overrun
    );

    modport slave (
`ifdef SND_MIX_CLIP_CNT_EN
        output clip_cnt,
`endif
        input  snd_next_sample, ch_l, ch_r, vol_we, vol_addr, vol_dat, mute, ovr_clr,
        output snd_l, snd_r, mix_busy, mix_done, overrun
    );

endinterface

// File: rtl/snd_mix_vol_regs.sv
// rtl/snd_mix_vol_regs.sv - per-channel volume registers with a snapshot copy taken at mix start
module snd_mix_vol_regs #(
    parameter int CHANNELS = 4,
    parameter int VOL_W    = 8,
    parameter int AW       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [AW-1:0]             addr,
    input  logic [VOL_W-1:0]          dat,
    input  logic                      snap,
    output logic [CHANNELS*VOL_W-1:0] snap_vol
);

    localparam logic [VOL_W-1:0] VOL_UNITY = {1'b1, {(VOL_W-1){1'b0}}};

    logic [CHANNELS*VOL_W-1:0] vol;

    // Addresses at or above CHANNELS match no slot, so such writes fall away.
    always_ff @(posedge clk) begin
        if (rst) begin
            vol      <= {CHANNELS{VOL_UNITY}};
            snap_vol <= {CHANNELS{VOL_UNITY}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (we && (addr == AW'(i))) begin
                    vol[i*VOL_W +: VOL_W] <= dat;
                end
            end
            if (snap) begin
                snap_vol <= vol;
            end
        end
    end

endmodule

// File: rtl/snd_mixer.sv
// rtl/snd_mixer.sv - sequential-MAC stereo mixer feeding I2S; clip counter under SND_MIX_CLIP_CNT_EN
module snd_mixer
    import snd_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int VOL_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    snd_mixer_if.slave  bus
);

    localparam int IW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW    = 16 + VOL_W + 1;
    localparam int ACC_W = PW + $clog2(CHANNELS);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MAC  = MAC;
    localparam logic [1:0] S_SAT  = SAT;

    logic [1:0]                 state;
    logic [IW-1:0]              idx;
    logic [CHANNELS*16-1:0]     snap_l;
    logic [CHANNELS*16-1:0]     snap_r;
    logic [CHANNELS*VOL_W-1:0]  snap_vol;
    logic signed [ACC_W-1:0]    acc_l;
    logic signed [ACC_W-1:0]    acc_r;
    snd_sample_t                out_l;
    snd_sample_t                out_r;
    logic                       busy_q;
    logic                       done_q;
    logic                       ovr_q;

    snd_sample_t                cur_l;
    snd_sample_t                cur_r;
    logic [VOL_W-1:0]           cur_v;
    logic signed [PW-1:0]       prod_l;
    logic signed [PW-1:0]       prod_r;
    logic signed [ACC_W-1:0]    sh_l;
    logic signed [ACC_W-1:0]    sh_r;
    logic                       clip_l;
    logic                       clip_r;
    logic                       accept;

    assign accept = bus.snd_next_sample && (state == S_IDLE);

    snd_mix_vol_regs #(
        .CHANNELS (CHANNELS),
        .VOL_W    (VOL_W),
        .AW       (IW)
    ) u_vol_regs (
        .clk      (clk),
        .rst      (rst),
        .we       (bus.vol_we),
        .addr     (bus.vol_addr),
        .dat      (bus.vol_dat),
        .snap     (accept),
        .snap_vol (snap_vol)
    );

    always_comb begin
        cur_l = '0;
        cur_r = '0;
        cur_v = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == IW'(i)) begin
                cur_l = snap_l[i*16 +: 16];
                cur_r = snap_r[i*16 +: 16];
                cur_v = snap_vol[i*VOL_W +: VOL_W];
            end
        end
        // Volume is unsigned; the extra zero bit keeps the product signed-correct.
        prod_l = cur_l * $signed({1'b0, cur_v});
        prod_r = cur_r * $signed({1'b0, cur_v});
        sh_l   = acc_l >>> (VOL_W - 1);
        sh_r   = acc_r >>> (VOL_W - 1);
        clip_l = (sh_l > ACC_W'(SND_MAX)) || (sh_l < ACC_W'(SND_MIN));
        clip_r = (sh_r > ACC_W'(SND_MAX)) || (sh_r < ACC_W'(SND_MIN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            snap_l <= '0;
            snap_r <= '0;
            acc_l  <= '0;
            acc_r  <= '0;
            out_l  <= '0;
            out_r  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.snd_next_sample && (state != S_IDLE)) begin
                ovr_q <= 1'b1;
            end else if (bus.ovr_clr) begin
                ovr_q <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (bus.snd_next_sample) begin
                        snap_l <= bus.ch_l;
                        snap_r <= bus.ch_r;
                        acc_l  <= '0;
                        acc_r  <= '0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_l <= acc_l + ACC_W'(prod_l);
                    acc_r <= acc_r + ACC_W'(prod_r);
                    idx   <= idx + IW'(1);
                    if (idx == IW'(CHANNELS - 1)) begin
                        state <= S_SAT;
                    end
                end
                S_SAT: begin
                    out_l  <= bus.mute ? snd_sample_t'(0) : snd_sat(64'(sh_l));
                    out_r  <= bus.mute ? snd_sample_t'(0) : snd_sat(64'(sh_r));
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SND_MIX_CLIP_CNT_EN
    logic [15:0] clip_q;

    // One count per sample, whichever side clamped; holds at all-ones.
    always_ff @(posedge clk) begin
        if (rst || bus.ovr_clr) begin
            clip_q <= '0;
        end else if ((state == S_SAT) && (clip_l || clip_r) && (clip_q != 16'hFFFF)) begin
            clip_q <= clip_q + 16'd1;
        end
    end

    assign bus.clip_cnt = clip_q;
`endif

    assign bus.snd_l    = out_l;
    assign bus.snd_r    = out_r;
    assign bus.mix_busy = busy_q;
    assign bus.mix_done = done_q;
    assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_snd_mixer.sv
// tb/tb_snd_mixer.sv - directed bench for snd_mixer; also checks clip_cnt under SND_MIX_CLIP_CNT_EN
module tb_snd_mixer;
    import snd_pkg::*;

    localparam int CH = 4;
    localparam int VW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   dones;
    logic found;

    always #5 clk = ~clk;

    snd_mixer_if #(.CHANNELS(CH), .VOL_W(VW)) bus ();

    snd_mixer #(.CHANNELS(CH), .VOL_W(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_ch();
        bus.ch_l = '0;
        bus.ch_r = '0;
    endtask

    task automatic set_ch(input int i, input int l, input int r);
        bus.ch_l[i*16 +: 16] = 16'(l);
        bus.ch_r[i*16 +: 16] = 16'(r);
    endtask

    task automatic wvol(input int a, input int d);
        bus.vol_addr = 2'(a);
        bus.vol_dat  = 8'(d);
        bus.vol_we   = 1'b1;
        step();
        bus.vol_we   = 1'b0;
    endtask

    // Pulses a request and expects mix_done exactly CH+1 edges after the sampling edge.
    task automatic run_mix(input string tag);
        int lat;
        bus.snd_next_sample = 1'b1;
        step();
        bus.snd_next_sample = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) chk({tag, "_busy"}, 32'(bus.mix_busy), 1);
            if (bus.mix_done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, CH + 1);
    endtask

    task automatic wait_done(input string tag);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.mix_done) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk({tag, "_done_seen"}, 32'(found), 1);
    endtask

    initial begin
        bus.snd_next_sample = 1'b0;
        bus.ch_l = '0;
        bus.ch_r = '0;
        bus.vol_we = 1'b0;
        bus.vol_addr = '0;
        bus.vol_dat = '0;
        bus.mute = 1'b0;
        bus.ovr_clr = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_l", bus.snd_l, 0);
        chk("rst_r", bus.snd_r, 0);
        chk("rst_busy", 32'(bus.mix_busy), 0);
        chk("rst_done", 32'(bus.mix_done), 0);
        chk("rst_ovr", 32'(bus.overrun), 0);
`ifdef SND_MIX_CLIP_CNT_EN
        chk("rst_clip", 32'(bus.clip_cnt), 0);
`endif

        clr_ch();
        set_ch(0, 1000, -1000);
        run_mix("unity");
        chk("unity_l", bus.snd_l, 1000);
        chk("unity_r", bus.snd_r, -1000);
        step();
        chk("unity_one_pulse", 32'(bus.mix_done), 0);
        chk("unity_idle", 32'(bus.mix_busy), 0);

        clr_ch();
        wvol(0, 'h40);
        wvol(1, 'h00);
        set_ch(0, 2000, 0);
        set_ch(1, 2000, 0);
        run_mix("half");
        chk("half_l", bus.snd_l, 1000);
        chk("half_r", bus.snd_r, 0);

        clr_ch();
        set_ch(0, -3, 0);
        run_mix("trunc");
        chk("trunc_l", bus.snd_l, -2);

        for (int i = 0; i < CH; i++) wvol(i, 'hFF);
        for (int i = 0; i < CH; i++) set_ch(i, 32767, -32768);
        run_mix("sat");
        chk("sat_l", bus.snd_l, 32767);
        chk("sat_r", bus.snd_r, -32768);
`ifdef SND_MIX_CLIP_CNT_EN
        chk("sat_clip", 32'(bus.clip_cnt), 1);
`endif

        for (int i = 0; i < CH; i++) wvol(i, 'h80);
        clr_ch();
        set_ch(0, 100, 50);
        bus.snd_next_sample = 1'b1;
        step();
        bus.snd_next_sample = 1'b0;
        step();
        set_ch(0, 200, 60);
        bus.snd_next_sample = 1'b1;
        step();
        bus.snd_next_sample = 1'b0;
        chk("ovr_set", 32'(bus.overrun), 1);
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.mix_done) begin
                dones++;
                chk("ovr_first_l", bus.snd_l, 100);
                chk("ovr_first_r", bus.snd_r, 50);
            end
        end
        chk("ovr_single_done", dones, 1);
        chk("ovr_sticky", 32'(bus.overrun), 1);
        bus.ovr_clr = 1'b1;
        step();
        bus.ovr_clr = 1'b0;
        chk("ovr_clr", 32'(bus.overrun), 0);
`ifdef SND_MIX_CLIP_CNT_EN
        chk("clip_clr", 32'(bus.clip_cnt), 0);
`endif

        clr_ch();
        set_ch(0, 1000, 1000);
        bus.snd_next_sample = 1'b1;
        step();
        bus.snd_next_sample = 1'b0;
        step();
        wvol(0, 'h00);
        wait_done("volmid");
        chk("volmid_l", bus.snd_l, 1000);
        chk("volmid_r", bus.snd_r, 1000);
        step();
        run_mix("volnext");
        chk("volnext_l", bus.snd_l, 0);
        chk("volnext_r", bus.snd_r, 0);

        wvol(0, 'h80);
        set_ch(0, 500, -500);
        run_mix("pre_rst");
        chk("pre_rst_l", bus.snd_l, 500);
        wvol(0, 'h40);
        set_ch(0, 900, 900);
        bus.snd_next_sample = 1'b1;
        step();
        bus.snd_next_sample = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.mix_busy), 0);
        chk("midrst_l", bus.snd_l, 0);
        chk("midrst_r", bus.snd_r, 0);
        chk("midrst_done", 32'(bus.mix_done), 0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.mix_done) dones++;
        end
        chk("midrst_no_done", dones, 0);
        clr_ch();
        set_ch(0, 700, -700);
        run_mix("fresh");
        chk("fresh_l", bus.snd_l, 700);
        chk("fresh_r", bus.snd_r, -700);

        bus.mute = 1'b1;
        run_mix("mute");
        chk("mute_l", bus.snd_l, 0);
        chk("mute_r", bus.snd_r, 0);
        bus.mute = 1'b0;
        step();
        chk("mute_hold_l", bus.snd_l, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
